// File: rtl/result_line_packer.sv
// Packs FP16 results into 256-bit lines and queues them in a first-word-fall-through line FIFO.
// Line port handshake: a line moves when o_line_valid && i_line_ready are both high on a rising clock edge.
module result_line_packer #(
   parameter int DATA_W       = 16,
   parameter int LANES        = 16,
   parameter int FIFO_DEPTH   = 32,
   parameter int AFULL_MARGIN = 4
) (
   input  logic                              i_clk,
   input  logic                              i_reset_n,
   input  logic                              i_tile_en,
   input  logic                              i_flush,
   input  logic [DATA_W-1:0]                 i_result_data,
   input  logic                              i_result_valid,
   output logic                              o_result_full,
   output logic                              o_result_afull,
   output logic [DATA_W*LANES-1:0]           o_line_data,
   output logic                              o_line_valid,
   input  logic                              i_line_ready,
   output logic                              o_flush_done,
   output logic                              o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]       o_fifo_level,
   output logic [15:0]                       o_result_count,
   output logic [1:0]                        o_state
);

   localparam int LINE_W = DATA_W * LANES;
   localparam int LANE_W = $clog2(LANES);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam logic [LVL_W-1:0]  DEPTH_L  = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]  AFULL_L  = LVL_W'(FIFO_DEPTH - AFULL_MARGIN);
   localparam logic [LANE_W-1:0] LAST_LN  = LANE_W'(LANES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [LINE_W-1:0]   pack_q, pack_d;
   logic [15:0]         count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                flush_done_q, flush_done_d;
   logic                full_q, full_d;
   logic                afull_q, afull_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;

   logic [LINE_W-1:0]   line_mem [FIFO_DEPTH];

   logic                pop;
   logic                push_req;
   logic                push_ok;
   logic [LINE_W-1:0]   push_data;
   logic [LANE_W-1:0]   lane_n;
   logic [LINE_W-1:0]   pack_n;

   always_comb begin
      pop          = (level_q != '0) && i_line_ready;
      push_req     = 1'b0;
      push_data    = '0;
      lane_n       = lane_q;
      pack_n       = pack_q;
      state_d      = state_q;
      lane_d       = lane_q;
      pack_d       = pack_q;
      count_d      = count_q;
      ovf_d        = ovf_q;
      flush_done_d = 1'b0;

      if (i_tile_en) begin
         state_d = ST_IDLE;
         lane_d  = '0;
         pack_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (state_q == ST_FLUSH) begin
         // Unused lanes are already zero because the pack register is cleared after every line.
         push_req  = 1'b1;
         push_data = pack_q;
         if (i_result_valid) ovf_d = 1'b1;
         if ((level_q != DEPTH_L) || pop) begin
            state_d      = ST_IDLE;
            lane_d       = '0;
            pack_d       = '0;
            flush_done_d = 1'b1;
         end
      end else begin
         if (i_result_valid) begin
            count_d = count_q + 16'd1;
            for (int k = 0; k < LANES; k++) begin
               if (lane_q == LANE_W'(k)) pack_n[k*DATA_W +: DATA_W] = i_result_data;
            end
            if (lane_q == LAST_LN) begin
               push_req  = 1'b1;
               push_data = pack_n;
               if (!((level_q != DEPTH_L) || pop)) ovf_d = 1'b1;
               lane_n  = '0;
               pack_n  = '0;
               state_d = ST_IDLE;
            end else begin
               lane_n  = lane_q + LANE_W'(1);
               state_d = ST_FILL;
            end
         end
         // Flush sees the lane count after this cycle's result has been packed.
         if (i_flush) begin
            if (lane_n == '0) flush_done_d = 1'b1;
            else              state_d      = ST_FLUSH;
         end
         lane_d = lane_n;
         pack_d = pack_n;
      end

      push_ok = push_req && ((level_q != DEPTH_L) || pop);

      unique case ({push_ok, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      full_d  = (level_d == DEPTH_L);
      afull_d = (level_d >= AFULL_L);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= ST_IDLE;
         lane_q       <= '0;
         pack_q       <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         flush_done_q <= 1'b0;
         full_q       <= 1'b0;
         afull_q      <= 1'b0;
         level_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         pack_q       <= pack_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         flush_done_q <= flush_done_d;
         full_q       <= full_d;
         afull_q      <= afull_d;
         level_q      <= level_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Storage is not reset; the head output is masked while the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (push_ok) line_mem[wr_ptr_q] <= push_data;
   end

   assign o_line_valid   = (level_q != '0);
   assign o_line_data    = (level_q != '0) ? line_mem[rd_ptr_q] : '0;
   assign o_result_full  = full_q;
   assign o_result_afull = afull_q;
   assign o_flush_done   = flush_done_q;
   assign o_overflow     = ovf_q;
   assign o_fifo_level   = level_q;
   assign o_result_count = count_q;
   assign o_state        = state_q;

endmodule

// File: tb/tb_result_line_packer.sv
// Directed bench for result_line_packer: packing, flush, back-pressure, overflow and tile clear.
module tb_result_line_packer;

   logic          i_clk;
   logic          i_reset_n;
   logic          i_tile_en;
   logic          i_flush;
   logic [15:0]   i_result_data;
   logic          i_result_valid;
   logic          o_result_full;
   logic          o_result_afull;
   logic [255:0]  o_line_data;
   logic          o_line_valid;
   logic          i_line_ready;
   logic          o_flush_done;
   logic          o_overflow;
   logic [5:0]    o_fifo_level;
   logic [15:0]   o_result_count;
   logic [1:0]    o_state;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [255:0] exp_q[$];

   result_line_packer dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_tile_en      (i_tile_en),
      .i_flush        (i_flush),
      .i_result_data  (i_result_data),
      .i_result_valid (i_result_valid),
      .o_result_full  (o_result_full),
      .o_result_afull (o_result_afull),
      .o_line_data    (o_line_data),
      .o_line_valid   (o_line_valid),
      .i_line_ready   (i_line_ready),
      .o_flush_done   (o_flush_done),
      .o_overflow     (o_overflow),
      .o_fifo_level   (o_fifo_level),
      .o_result_count (o_result_count),
      .o_state        (o_state)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [255:0] mk_line(input logic [15:0] base, input int n);
      logic [255:0] l;
      l = '0;
      for (int k = 0; k < n; k++) l[k*16 +: 16] = base + 16'(k);
      return l;
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge i_clk);
      #1;
      i_result_valid = 1'b0;
      i_flush        = 1'b0;
      i_tile_en      = 1'b0;
      i_result_data  = '0;
   endtask

   task automatic send(input logic [15:0] d);
      i_result_valid = 1'b1;
      i_result_data  = d;
      tick();
   endtask

   task automatic send_lines(input logic [15:0] base, input int first, input int n);
      for (int i = first; i < first + n; i++)
         for (int k = 0; k < 16; k++) send(base + 16'(i*16 + k));
   endtask

   task automatic drain_sb(input string tag);
      i_line_ready = 1'b1;
      while (exp_q.size() != 0) begin
         chk(tag, o_line_data, exp_q.pop_front());
         tick();
      end
      chk({tag, "_empty"}, {255'b0, o_line_valid}, 256'd0);
      i_line_ready = 1'b0;
   endtask

   initial begin
      i_reset_n = 1'b0; i_tile_en = 1'b0; i_flush = 1'b0;
      i_result_data = '0; i_result_valid = 1'b0; i_line_ready = 1'b0;
      tick(); tick();
      chk("rst_full",  o_result_full,  0);
      chk("rst_afull", o_result_afull, 0);
      chk("rst_valid", o_line_valid,   0);
      chk("rst_data",  o_line_data,    0);
      chk("rst_fdone", o_flush_done,   0);
      chk("rst_ovf",   o_overflow,     0);
      chk("rst_level", o_fifo_level,   0);
      chk("rst_count", o_result_count, 0);
      chk("rst_state", o_state,        0);
      i_reset_n = 1'b1;
      tick();

      // one full line with consumer ready
      i_line_ready = 1'b1;
      for (int k = 0; k < 15; k++) send(16'(k + 1));
      chk("t1_no_early_valid", o_line_valid, 0);
      send(16'h0010);
      chk("t1_valid", o_line_valid, 1);
      chk("t1_line",  o_line_data, mk_line(16'h0001, 16));
      chk("t1_lane0", o_line_data[15:0], 16'h0001);
      chk("t1_lane15", o_line_data[255:240], 16'h0010);
      chk("t1_count", o_result_count, 16);
      chk("t1_level", o_fifo_level, 1);
      tick();
      chk("t1_popped", o_fifo_level, 0);

      // 20 results then flush of a 4-lane partial line
      i_line_ready = 1'b0;
      for (int k = 0; k < 20; k++) send(16'h0100 + 16'(k));
      chk("t2_level1", o_fifo_level, 1);
      i_flush = 1'b1;
      tick();
      chk("t2_state_flush", o_state, 2);
      chk("t2_no_done_yet", o_flush_done, 0);
      tick();
      chk("t2_level2", o_fifo_level, 2);
      chk("t2_done", o_flush_done, 1);
      chk("t2_state_idle", o_state, 0);
      chk("t2_count", o_result_count, 36);
      tick();
      chk("t2_done_pulse", o_flush_done, 0);
      exp_q.push_back(mk_line(16'h0100, 16));
      exp_q.push_back(mk_line(16'h0110, 4));
      drain_sb("t2_drain");

      // flush with nothing pending
      i_flush = 1'b1;
      tick();
      chk("idle_flush_done", o_flush_done, 1);
      chk("idle_flush_level", o_fifo_level, 0);
      tick();
      chk("idle_flush_pulse", o_flush_done, 0);

      // afull / full / overflow with consumer stalled
      i_tile_en = 1'b1;
      tick();
      send_lines(16'h0000, 0, 27);
      chk("t3_level27", o_fifo_level, 27);
      chk("t3_afull_lo", o_result_afull, 0);
      send_lines(16'h0000, 27, 1);
      chk("t3_level28", o_fifo_level, 28);
      chk("t3_afull_hi", o_result_afull, 1);
      send_lines(16'h0000, 28, 3);
      chk("t3_full_lo", o_result_full, 0);
      send_lines(16'h0000, 31, 1);
      chk("t3_level32", o_fifo_level, 32);
      chk("t3_full_hi", o_result_full, 1);
      chk("t3_no_ovf", o_overflow, 0);
      send_lines(16'h0000, 32, 1);
      chk("t3_ovf", o_overflow, 1);
      chk("t3_level_hold", o_fifo_level, 32);
      chk("t3_count", o_result_count, 528);
      for (int i = 0; i < 32; i++) exp_q.push_back(mk_line(16'(i*16), 16));
      drain_sb("t3_drain");
      chk("t3_full_clr", o_result_full, 0);
      chk("t3_afull_clr", o_result_afull, 0);

      // push accepted into a full FIFO on a pop cycle
      i_tile_en = 1'b1;
      tick();
      chk("t4_ovf_cleared", o_overflow, 0);
      send_lines(16'h1000, 0, 32);
      for (int k = 0; k < 15; k++) send(16'h1200 + 16'(k));
      chk("t4_full", o_result_full, 1);
      i_line_ready = 1'b1;
      chk("t4_head", o_line_data, mk_line(16'h1000, 16));
      send(16'h120F);
      chk("t4_level", o_fifo_level, 32);
      chk("t4_no_ovf", o_overflow, 0);
      chk("t4_count", o_result_count, 528);
      for (int i = 1; i < 33; i++) exp_q.push_back(mk_line(16'h1000 + 16'(i*16), 16));
      drain_sb("t4_drain");

      // flush arriving with the lane-15 result
      i_tile_en = 1'b1;
      tick();
      for (int k = 0; k < 15; k++) send(16'h2000 + 16'(k));
      i_flush = 1'b1;
      send(16'h200F);
      chk("t5_level", o_fifo_level, 1);
      chk("t5_done", o_flush_done, 1);
      chk("t5_state", o_state, 0);
      tick();
      chk("t5_no_pad", o_fifo_level, 1);
      chk("t5_done_pulse", o_flush_done, 0);
      exp_q.push_back(mk_line(16'h2000, 16));

      // tile_en mid-line discards the partial line but keeps queued lines
      for (int k = 0; k < 5; k++) send(16'h3000 + 16'(k));
      i_tile_en = 1'b1;
      send(16'h3005);
      chk("t6_level", o_fifo_level, 1);
      chk("t6_count", o_result_count, 0);
      chk("t6_state", o_state, 0);
      for (int k = 0; k < 16; k++) send(16'h3100 + 16'(k));
      chk("t6_level2", o_fifo_level, 2);
      chk("t6_count16", o_result_count, 16);
      exp_q.push_back(mk_line(16'h3100, 16));
      drain_sb("t6_drain");

      // result offered during flush is dropped and flagged
      i_tile_en = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) send(16'h4000 + 16'(k));
      i_flush = 1'b1;
      tick();
      chk("t7_state_flush", o_state, 2);
      send(16'h4444);
      chk("t7_ovf", o_overflow, 1);
      chk("t7_count", o_result_count, 3);
      chk("t7_done", o_flush_done, 1);
      chk("t7_level", o_fifo_level, 1);
      chk("t7_line", o_line_data, mk_line(16'h4000, 3));

      // asynchronous reset mid-operation
      #2 i_reset_n = 1'b0;
      #1;
      chk("rst2_level", o_fifo_level, 0);
      chk("rst2_valid", o_line_valid, 0);
      chk("rst2_data", o_line_data, 0);
      chk("rst2_ovf", o_overflow, 0);
      i_reset_n = 1'b1;
      tick();

      // final report
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
